// File: rtl/alu_op_sequencer.sv
// Issue stage for the 64-bit Simple ALU: queues ops, issues one at a time, returns X/Y results.
// Latency: accept at edge N -> ALU inputs after N+1 -> out_valid after N+2; one result per 2 cycles sustained.
// Backpressure: out_ready=0 parks the result in HOLD; the FIFO keeps accepting until full, then in_ready=0.

module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_vld,
  output logic          wr_rdy,
  input  logic [W-1:0]  wr_dat,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic [W-1:0]  rd_dat,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_fire;
  logic          rd_fire;

  // Full blocks writes even if a read happens on the same edge.
  assign wr_rdy  = (count < CW'(DEPTH));
  assign rd_vld  = (count != '0);
  assign wr_fire = wr_vld && wr_rdy;
  assign rd_fire = rd_vld && rd_rdy;
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_fire) - CW'(rd_fire);
    end
  end
endmodule

module alu_op_sequencer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [2:0]        in_cmd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_cmd,
  input  logic [DATA_W-1:0] alu_x,
  input  logic [DATA_W-1:0] alu_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y,
  output logic [2:0]        out_cmd,
  output logic [CW-1:0]     count
);
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        cmd;
  } op_t;

  typedef enum logic [1:0] {s_idle, s_exec, s_hold} state_t;

  state_t state;
  op_t    in_op;
  op_t    head_op;
  logic   head_vld;
  logic   head_rdy;
  logic   nop_cmd;

  assign in_op = '{a: in_a, b: in_b, cmd: in_cmd};

  // The FIFO head is consumed exactly when the FSM loads the ALU registers.
  assign head_rdy = (state == s_idle) || ((state == s_hold) && out_ready);
  assign nop_cmd  = (alu_cmd == 3'b000);

  fifo #(
    .W     ($bits(op_t)),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (in_valid),
    .wr_rdy (in_ready),
    .wr_dat (in_op),
    .rd_vld (head_vld),
    .rd_rdy (head_rdy),
    .rd_dat (head_op),
    .count  (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= s_idle;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cmd   <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_cmd   <= '0;
    end else begin
      case (state)
        s_idle: begin
          if (head_vld) begin
            alu_a   <= head_op.a;
            alu_b   <= head_op.b;
            alu_cmd <= head_op.cmd;
            state   <= s_exec;
          end
        end
        s_exec: begin
          out_x     <= nop_cmd ? '0 : alu_x;
          out_y     <= nop_cmd ? '0 : alu_y;
          out_cmd   <= alu_cmd;
          out_valid <= 1'b1;
          state     <= s_hold;
        end
        s_hold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (head_vld) begin
              alu_a   <= head_op.a;
              alu_b   <= head_op.b;
              alu_cmd <= head_op.cmd;
              state   <= s_exec;
            end else begin
              state <= s_idle;
            end
          end
        end
        default: state <= s_idle;
      endcase
    end
  end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Issue stage directly upstream of the 64-bit Simple ALU. It accepts ALU operations (A, B, 3-bit command) over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It issues one operation at a time to the combinational ALU through registered operand/command outputs, captures the ALU's X/Y results, and presents them downstream over a second valid/ready handshake.

## Interface
- DATA_W, 64, operand/result width; matches the ALU.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CW, $clog2(DEPTH)+1, derived width of the occupancy count.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- in_valid  in  1  upstream presents an operation.
- in_ready  out  1  FIFO can accept; equals (count < DEPTH).
- in_a, in_b  in  DATA_W  operands.
- in_cmd  in  3  command: 000 NOP, 001 ADD, 010 SUB, 011 SLL, 100 SLR, 101 AND, 110 OR, 111 XOR.
- alu_a, alu_b  out  DATA_W  registered operands to the ALU A/B inputs.
- alu_cmd  out  3  registered command to the ALU cmd input.
- alu_x, alu_y  in  DATA_W  ALU results X, Y (combinational from alu_a/b/cmd).
- out_valid  out  1  result held on out_x/out_y/out_cmd.
- out_ready  in  1  downstream accepts the result.
- out_x, out_y  out  DATA_W  captured results.
- out_cmd  out  3  command that produced the result.
- count  out  CW  current FIFO occupancy, 0..DEPTH.

## Operation
- Push: in_valid && in_ready at a rising edge writes {in_a, in_b, in_cmd} at the write pointer. Both pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if count != 0, pop the head into alu_a/alu_b/alu_cmd, then go to EXEC.
  - EXEC: exactly one cycle. Capture alu_x/alu_y into out_x/out_y and alu_cmd into out_cmd, set out_valid, then go to HOLD.
  - HOLD: out_valid=1. When out_ready=1, clear out_valid. In the same edge, if count != 0, pop the next entry and go to EXEC; otherwise go to IDLE.
- NOP results: out_x and out_y are forced to 0. The result is still emitted with out_cmd=000.
- Push and pop in the same edge are allowed. count is unchanged in that case.
- When full (count==DEPTH), in_ready=0 even if a pop occurs in the same edge. No push-through when full.
- Holding out_ready=0 stalls in HOLD indefinitely. The FIFO keeps accepting until full.
- alu_a/alu_b/alu_cmd keep their last issued values between operations.
- Result widths equal DATA_W. Results are taken from the ALU unmodified (SUB wraps two's complement); no overflow flags.
- Reset (rst_n=0, any time, including mid-operation) forces IDLE, clears pointers, count=0, out_valid=0, and clears out_x/out_y/out_cmd/alu_a/alu_b/alu_cmd to 0. Queued and in-flight operations are discarded. in_ready=1 during and after reset.

## Timing
- Accept at edge N:
  - the entry is poppable at edge N+1 (from IDLE);
  - the ALU inputs are valid after N+1;
  - the result is captured at N+2;
  - out_valid=1 after N+2 (2-cycle latency).
- Sustained throughput is one result per 2 cycles with out_ready held at 1: HOLD→EXEC→HOLD.
- out_x/out_y/out_cmd are stable while out_valid=1 and out_ready=0.
- in_ready and count are registered-state derived; there is no combinational path from out_ready to in_ready.

## Test plan
- Reset, then issue ADD 10,30; SUB 80,160; SLL 2,5; SLR 15,3; AND 36,20; OR 31,32; XOR 255,126 with out_ready=1. Required out_x, in order: 40, 64'hFFFF_FFFF_FFFF_FFB0, 64, 1, 4, 63, 129, each with the matching out_cmd.
- Single ADD 10,30 accepted at edge N. Required: out_valid rises after edge N+2; count returns to 0.
- out_ready=0; push 5 ops with DEPTH=4. Required: 1 op in flight, then 4 accepted; in_ready=0 with count=4. Release out_ready: all 5 results emerge in order, and in_ready returns to 1 after the first pop.
- NOP with A=7, B=9. Required: out_valid pulse with out_x=0, out_y=0, out_cmd=000.
- Queue 3 ops, then assert rst_n=0 while in EXEC. Required: out_valid=0, count=0, all outputs 0 immediately (asynchronous). After release, no stale results appear and a fresh ADD 1,1 yields 2.
- Simultaneous push and pop with count=2. Required: count stays 2 and order is preserved across pointer wrap (push ≥9 ops).
